// File: rtl/lda_pkg.sv
// lda_pkg: register map, STATUS bit indices, dispatcher states and command layout for the LDA command queue
package lda_pkg;
  localparam int LDA_X_W = 9;
  localparam int LDA_Y_W = 8;
  localparam int LDA_COLOR_W = 3;
  localparam logic [2:0] ADDR_MODE = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_GO = 3'd2;
  localparam logic [2:0] ADDR_START = 3'd3;
  localparam logic [2:0] ADDR_END = 3'd4;
  localparam logic [2:0] ADDR_COLOR = 3'd5;
  localparam logic [2:0] ADDR_CLEAR = 3'd6;
  localparam logic [2:0] ADDR_SYNC = 3'd7;
  localparam int ST_BUSY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVF = 2;
  localparam int ST_IRQ = 3;
  localparam int ST_CNT = 8;
  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY} lda_state_t;
  typedef struct packed {
    logic [LDA_X_W-1:0] x0;
    logic [LDA_Y_W-1:0] y0;
    logic [LDA_X_W-1:0] x1;
    logic [LDA_Y_W-1:0] y1;
    logic [LDA_COLOR_W-1:0] color;
  } lda_cmd_t;
endpackage

// File: rtl/lda_cmd_fifo.sv
// lda_cmd_fifo: synchronous DEPTH-entry command FIFO with flush; ports: push/wdata in, pop/rdata (head) out, full/empty/count status
module lda_cmd_fifo #(
  parameter int W = 37,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == CNT_W'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = mem[rp];
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wdata;
endmodule

// File: rtl/lda_avalon_cmd_queue.sv
// lda_avalon_cmd_queue: Avalon-MM front end queueing line-draw commands and dispatching them to the draw engine
// Ports: Avalon slave (s_address/s_read/s_write/s_writedata/s_readdata/s_waitrequest), engine handshake (o_start/i_done),
// command outputs o_x0/o_y0/o_x1/o_y1/o_color; o_irq exists only when LDA_QUEUE_IRQ_EN is defined.
module lda_avalon_cmd_queue
  import lda_pkg::*;
#(
  parameter int X_W = 9,
  parameter int Y_W = 8,
  parameter int COLOR_W = 3,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         s_address,
  input  logic               s_read,
  input  logic               s_write,
  input  logic [31:0]        s_writedata,
  output logic [31:0]        s_readdata,
  output logic               s_waitrequest,
  input  logic               i_done,
`ifdef LDA_QUEUE_IRQ_EN
  output logic               o_irq,
`endif
  output logic               o_start,
  output logic [X_W-1:0]     o_x0,
  output logic [Y_W-1:0]     o_y0,
  output logic [X_W-1:0]     o_x1,
  output logic [Y_W-1:0]     o_y1,
  output logic [COLOR_W-1:0] o_color
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int W = 2 * (X_W + Y_W) + COLOR_W;
`ifdef LDA_QUEUE_IRQ_EN
  localparam logic [1:0] MODE_MSK = 2'b11;
`else
  localparam logic [1:0] MODE_MSK = 2'b01;
`endif
  lda_state_t state, nxt;
  logic [1:0] mode;
  logic [X_W-1:0] sx0, sx1;
  logic [Y_W-1:0] sy0, sy1;
  logic [COLOR_W-1:0] scolor;
  logic ovf, irq, busy, full, empty, push, pop, flush, wr_acc;
  logic [CNT_W-1:0] count;
  logic [W-1:0] head;
  logic [31:0] status;
  logic unused;
  assign unused = ^s_writedata;
  assign busy = state != IDLE || !empty;
  assign s_waitrequest = s_write && !mode[0] &&
    ((s_address == ADDR_GO && full) || (s_address == ADDR_SYNC && busy));
  assign wr_acc = s_write && !s_waitrequest;
  assign push = wr_acc && s_address == ADDR_GO;
  assign flush = wr_acc && s_address == ADDR_CLEAR;
  // A CLEAR landing on the IDLE->LAUNCH edge can empty the queue; LAUNCH then falls back without a start.
  assign pop = state == LAUNCH && !empty;
  lda_cmd_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk, .rst_n, .push, .pop, .flush,
    .wdata({sx0, sy0, sx1, sy1, scolor}),
    .rdata(head), .full, .empty, .count
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode <= '0;
      {sx0, sy0, sx1, sy1, scolor} <= '0;
      ovf <= 1'b0;
    end else begin
      if (wr_acc && s_address == ADDR_MODE) mode <= s_writedata[1:0] & MODE_MSK;
      if (wr_acc && s_address == ADDR_START) {sy0, sx0} <= s_writedata[X_W+Y_W-1:0];
      if (wr_acc && s_address == ADDR_END) {sy1, sx1} <= s_writedata[X_W+Y_W-1:0];
      if (wr_acc && s_address == ADDR_COLOR) scolor <= s_writedata[COLOR_W-1:0];
      ovf <= flush ? 1'b0 : ovf | (push && full);
    end
  end
  always_ff @(posedge clk) state <= rst_n ? nxt : IDLE;
  always_comb
    nxt = state == IDLE ? (empty ? IDLE : LAUNCH) :
          state == LAUNCH ? (empty ? IDLE : BUSY) :
          (i_done ? IDLE : BUSY);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_start <= 1'b0;
      {o_x0, o_y0, o_x1, o_y1, o_color} <= '0;
    end else begin
      o_start <= pop;
      if (pop) {o_x0, o_y0, o_x1, o_y1, o_color} <= head;
    end
  end
`ifdef LDA_QUEUE_IRQ_EN
  always_ff @(posedge clk)
    irq <= (!rst_n || (wr_acc && s_address == ADDR_STATUS)) ? 1'b0 :
           irq | (state == BUSY && i_done && empty && mode[1]);
  assign o_irq = irq;
`else
  assign irq = 1'b0;
`endif
  always_comb begin
    status = 32'(count) << ST_CNT;
    status[ST_BUSY] = busy;
    status[ST_FULL] = full;
    status[ST_OVF] = ovf;
    status[ST_IRQ] = irq;
  end
  always_comb
    s_readdata = !s_read ? '0 :
                 s_address == ADDR_MODE ? 32'(mode) :
                 s_address == ADDR_STATUS ? status :
                 s_address == ADDR_START ? 32'({sy0, sx0}) :
                 s_address == ADDR_END ? 32'({sy1, sx1}) :
                 s_address == ADDR_COLOR ? 32'(scolor) : '0;
endmodule

// File: tb/tb_lda_avalon_cmd_queue.sv
// tb_lda_avalon_cmd_queue: scoreboard bench for the LDA command queue
module tb_lda_avalon_cmd_queue;
  logic clk = 0;
  logic rst_n = 0;
  logic [2:0] s_address = '0;
  logic s_read = 0, s_write = 0, i_done = 0;
  logic [31:0] s_writedata = '0;
  logic [31:0] s_readdata;
  logic s_waitrequest, o_start;
  logic [8:0] o_x0, o_x1;
  logic [7:0] o_y0, o_y1;
  logic [2:0] o_color;
`ifdef LDA_QUEUE_IRQ_EN
  logic o_irq;
`endif
  int n_cmp = 0, n_bad = 0;
  logic [63:0] cmdq [$];
  logic [31:0] rdq [$];
  localparam logic [63:0] CMD1 = 64'({9'h0FF, 8'h7F, 9'h1DA, 8'h81, 3'd5});
  localparam logic [63:0] CMD2 = 64'({9'd1, 8'd2, 9'd3, 8'd4, 3'd6});
  localparam logic [63:0] CMDA = 64'({9'h10, 8'h20, 9'h30, 8'h40, 3'd1});

  lda_avalon_cmd_queue dut (
    .clk(clk), .rst_n(rst_n), .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
    .i_done(i_done),
`ifdef LDA_QUEUE_IRQ_EN
    .o_irq(o_irq),
`endif
    .o_start(o_start), .o_x0(o_x0), .o_y0(o_y0), .o_x1(o_x1), .o_y1(o_y1), .o_color(o_color)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    int n = 0;
    s_address = a;
    s_writedata = d;
    s_write = 1;
    @(negedge clk);
    while (s_waitrequest && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wr_bound", 64'(s_waitrequest), 64'd0);
    @(posedge clk);
    #1;
    s_write = 0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp);
    rdq.push_back(exp);
    s_address = a;
    s_read = 1;
    @(posedge clk);
    #1;
    s_read = 0;
  endtask

  task automatic done();
    i_done = 1;
    @(posedge clk);
    #1;
    i_done = 0;
  endtask

  always @(negedge clk) begin
    if (o_start) begin
      if (cmdq.size() == 0) chk("start_unexpected", 64'd1, 64'd0);
      else chk("cmd", 64'({o_x0, o_y0, o_x1, o_y1, o_color}), cmdq.pop_front());
    end
    if (s_read && !s_waitrequest) begin
      if (rdq.size() == 0) chk("read_unexpected", 64'd1, 64'd0);
      else chk("readdata", 64'(s_readdata), 64'(rdq.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    rst_n = 1;
    chk("reset_out", 64'({o_start, o_x0, o_y0, o_x1, o_y1, o_color, s_waitrequest}), 64'd0);
    rd(1, 32'h0);
    rd(0, 32'h0);
    rd(3, 32'h0);
    wr(0, 32'h3);
`ifdef LDA_QUEUE_IRQ_EN
    rd(0, 32'h3);
`else
    rd(0, 32'h1);
`endif
    wr(0, 32'h1);
    wr(3, 32'h0000FEFF);
    wr(4, 32'h000103DA);
    wr(5, 32'h5);
    rd(3, 32'h0000FEFF);
    rd(4, 32'h000103DA);
    rd(5, 32'h5);
    cmdq.push_back(CMD1);
    wr(2, 32'h0);
    rd(1, 32'h101);
    @(negedge clk) chk("lat_pre", 64'(o_start), 64'd0);
    @(negedge clk) chk("lat_start", 64'(o_start), 64'd1);
    @(posedge clk) #1;
    rd(1, 32'h001);
    rd(2, 32'h0);
    rd(6, 32'h0);
    rd(7, 32'h0);
    done();
    rd(1, 32'h0);
    chk("hold_out", 64'({o_x0, o_y0, o_x1, o_y1, o_color}), CMD1);

    wr(3, 32'h401);
    wr(4, 32'h803);
    wr(5, 32'h6);
    cmdq.push_back(CMD2);
    wr(2, 32'h0);
    idle(3);
    repeat (5) wr(2, 32'h0);
    rd(1, 32'h407);
    wr(7, 32'h0);
    wr(6, 32'h0);
    rd(1, 32'h001);
    done();
    idle(4);
    rd(1, 32'h0);

    wr(0, 32'h0);
    wr(3, 32'h4010);
    wr(4, 32'h8030);
    wr(5, 32'h1);
    cmdq.push_back(CMDA);
    wr(2, 32'h0);
    idle(3);
    repeat (4) begin
      cmdq.push_back(CMDA);
      wr(2, 32'h0);
    end
    rd(1, 32'h403);
    fork
      begin
        cmdq.push_back(CMDA);
        wr(2, 32'h0);
      end
      begin
        idle(2);
        chk("stall_full", 64'(s_waitrequest), 64'd1);
        done();
        @(negedge clk) chk("stall_idle", 64'(s_waitrequest), 64'd1);
        @(negedge clk) chk("stall_launch", 64'(s_waitrequest), 64'd1);
        @(negedge clk) chk("stall_release", 64'(s_waitrequest), 64'd0);
      end
    join
    repeat (5) begin
      done();
      idle(4);
    end
    rd(1, 32'h0);

    cmdq.push_back(CMDA);
    cmdq.push_back(CMDA);
    wr(2, 32'h0);
    wr(2, 32'h0);
    fork
      wr(7, 32'h0);
      begin
        idle(3);
        chk("sync_1", 64'(s_waitrequest), 64'd1);
        done();
        idle(4);
        chk("sync_2", 64'(s_waitrequest), 64'd1);
        done();
        @(negedge clk) chk("sync_release", 64'(s_waitrequest), 64'd0);
      end
    join
    rd(1, 32'h0);

    wr(0, 32'h1);
    cmdq.push_back(CMDA);
    wr(2, 32'h0);
    idle(3);
    repeat (3) wr(2, 32'h0);
    rd(1, 32'h301);
    rst_n = 0;
    @(posedge clk) #1;
    rst_n = 1;
    chk("rst_out", 64'({o_start, o_x0, o_y0, o_x1, o_y1, o_color, s_waitrequest}), 64'd0);
    rd(1, 32'h0);
    rd(0, 32'h0);
    rd(3, 32'h0);
    done();
    idle(4);
    rd(1, 32'h0);

`ifdef LDA_QUEUE_IRQ_EN
    wr(0, 32'h3);
    wr(3, 32'h0000FEFF);
    wr(4, 32'h000103DA);
    wr(5, 32'h5);
    cmdq.push_back(CMD1);
    wr(2, 32'h0);
    idle(3);
    done();
    chk("irq_set", 64'(o_irq), 64'd1);
    rd(1, 32'h8);
    wr(1, 32'h0);
    chk("irq_clr", 64'(o_irq), 64'd0);
`endif

    idle(2);
    chk("cmdq_left", 64'(cmdq.size()), 64'd0);
    chk("rdq_left", 64'(rdq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lda_avalon_cmd_queue.md
Name: lda_avalon_cmd_queue

Overview:
Next-generation Avalon-MM slave front end for the line-drawing accelerator (LDA), replacing the single-command register controller. Software writes endpoints and color into staging registers, then writes GO to push the command into a DEPTH-entry FIFO. An internal dispatcher pops commands and launches the draw engine with a one-cycle o_start pulse, then waits for i_done. Coordinate and color widths, and queue depth, are parametrised. Stall and poll modes are retained.

Parameters:
X_W, 9, x coordinate width
Y_W, 8, y coordinate width
COLOR_W, 3, color width
DEPTH, 4, command queue entries (power of 2, >=2)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
s_address  in  3  word address
s_read  in  1  Avalon read
s_write  in  1  Avalon write
s_writedata  in  32  write data
s_readdata  out  32  read data, combinational, valid while s_read and !s_waitrequest
s_waitrequest  out  1  Avalon stall
i_done  in  1  engine done pulse
o_start  out  1  one-cycle launch pulse
o_x0  out  X_W  start x
o_y0  out  Y_W  start y
o_x1  out  X_W  end x
o_y1  out  Y_W  end y
o_color  out  COLOR_W  color

Behaviour:
- Single clock clk. Reset rst_n is synchronous and active-low. On reset: queue empty; FSM in IDLE; MODE=0; staging registers 0; overflow 0; o_start=0; all o_* coordinate and color outputs 0; s_waitrequest=0.
- Register map (write / read):
  - 0 MODE: bit0 0=stall, 1=poll.
  - 1 STATUS: read-only. bit0 busy = FSM!=IDLE or queue non-empty; bit1 full; bit2 overflow (sticky); bits [8 +: CNT_W] hold the entry count, with CNT_W = $clog2(DEPTH+1).
  - 2 GO: push the staged {start, end, color} into the queue.
  - 3 START: {y0[Y_W-1:0] at bits X_W+:Y_W, x0 at bits 0+:X_W}.
  - 4 END: same packing as START.
  - 5 COLOR: bits 0+:COLOR_W.
  - 6 CLEAR: flush queued entries and clear overflow. Does not abort the command in flight.
  - 7 SYNC: write-only barrier.
  - Addresses 2, 6 and 7 read as 0. Unused bits read as 0.
- A write is accepted on any edge where s_write=1 and s_waitrequest=0.
- Stall mode (MODE=0):
  - GO while the queue is full: s_waitrequest=1 until count<DEPTH, then the push is accepted.
  - SYNC: s_waitrequest=1 until busy=0.
- Poll mode (MODE=1):
  - s_waitrequest is always 0.
  - GO to a full queue is dropped and sets overflow.
  - SYNC completes immediately with no effect.
- Reads and all other addresses never stall.
- The full check uses the count before any same-cycle pop. There is no push/pop bypass.
- Dispatcher FSM:
  - IDLE: if the queue is non-empty, go to LAUNCH.
  - LAUNCH: pop the head into registered o_x0/o_y0/o_x1/o_y1/o_color, assert o_start for exactly this cycle, go to BUSY.
  - BUSY: on i_done=1, go to IDLE.
- Latency: with an idle engine, a GO accepted at edge N gives o_start=1 in the cycle after edge N+2.
- Outputs hold their values until the next LAUNCH.
- i_done outside BUSY is ignored.
- Back-to-back commands: from i_done to the next o_start is 2 cycles.
- CLEAR and GO accepted on the same edge cannot occur (single port). A CLEAR coinciding with a pop leaves the queue empty.
- Staging registers persist after GO, so GO can be repeated to re-queue the same line.

Optional Feature:
- Macro LDA_QUEUE_IRQ_EN.
- Defined:
  - Adds output port o_irq (1 bit, reset 0).
  - MODE bit1 = irq enable.
  - o_irq is set on the edge where the FSM enters IDLE from BUSY with the queue empty and irq enable=1.
  - o_irq is cleared by any accepted write to address 1, or by reset.
  - o_irq is visible as STATUS bit3.
- Undefined: no o_irq port, MODE bit1 and STATUS bit3 read 0.

Decomposition:
- Package lda_pkg holds:
  - register address localparams (ADDR_MODE … ADDR_SYNC),
  - STATUS bit index constants,
  - dispatcher state enum typedef (IDLE, LAUNCH, BUSY),
  - a packed struct typedef lda_cmd_t parametrised via package parameters matching the defaults.
- One sub-module, lda_cmd_fifo: a synchronous FIFO with push, pop, flush, full, empty and count, DEPTH deep, width = 2*(X_W+Y_W)+COLOR_W.

Test Plan:
- Poll mode, single command: START=0x0FF_7F, END=0x1DA_81, COLOR=5, GO -> o_start pulses once; o_x0=0xFF, o_y0=0x7F, o_x1=0x1DA, o_y1=0x81, o_color=5; STATUS bit0=1 until i_done, then 0.
- Poll mode, overflow: hold i_done=0 and issue 6 GOs (DEPTH=4) -> 1 entry in flight and count=4, so the 6th GO is dropped; overflow=1; CLEAR -> count=0 and overflow=0, while the in-flight command still completes on i_done.
- Stall mode, full queue: fill the queue, then GO -> s_waitrequest=1 until i_done frees a slot; the write is accepted on the edge after the pop.
- Stall mode, SYNC: with 2 commands queued, SYNC -> s_waitrequest stays 1 through both i_done pulses and deasserts when busy=0.
- Reset mid-draw: assert rst_n=0 during BUSY with 3 entries queued -> next cycle all outputs are 0, count=0, and a later i_done is ignored.
- LDA_QUEUE_IRQ_EN with MODE=3: run one command -> o_irq=1 after i_done; a write to address 1 clears it.
